// File: rtl/lane_unshifter_pkg.sv
// rtl/lane_unshifter_pkg.sv - shared constants, encodings and state type for the lane unshifter
package shift_pkg;

  localparam int LANES   = 8;
  localparam int LANE_W  = 4;
  localparam int SHIFT_W = $clog2(LANE_W);

  // Forward direction encoding; the unshifter moves data the other way.
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // Fill mode encoding.
  localparam logic SR_ROTATE = 1'b1;
  localparam logic SR_SHIFT  = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Amounts wider than a lane wrap; a no-op when LANE_W is a power of two.
  function automatic int unsigned wrap_amount(input int unsigned amt, input int unsigned lane_w);
    return amt % lane_w;
  endfunction

endpackage

// File: rtl/lane_unshifter_if.sv
// rtl/lane_unshifter_if.sv - command/result handshake bundle for the lane unshifter
interface lane_unshifter_if #(
  parameter int LANES   = shift_pkg::LANES,
  parameter int LANE_W  = shift_pkg::LANE_W,
  parameter int SHIFT_W = shift_pkg::SHIFT_W
);

  logic [LANES*LANE_W-1:0] lane_unshifter_port_input;
  logic                    lane_unshifter_port_sr;
  logic [SHIFT_W-1:0]      lane_unshifter_port_shift;
  logic                    lane_unshifter_port_direction;
  logic                    lane_unshifter_port_in_valid;
  logic                    lane_unshifter_port_in_ready;
  logic [LANES*LANE_W-1:0] lane_unshifter_port_output;
  logic                    lane_unshifter_port_lost;
  logic                    lane_unshifter_port_out_valid;
  logic                    lane_unshifter_port_out_ready;

  // Producer/consumer side driving commands and taking results.
  modport master (
    output lane_unshifter_port_input,
    output lane_unshifter_port_sr,
    output lane_unshifter_port_shift,
    output lane_unshifter_port_direction,
    output lane_unshifter_port_in_valid,
    input  lane_unshifter_port_in_ready,
    input  lane_unshifter_port_output,
    input  lane_unshifter_port_lost,
    input  lane_unshifter_port_out_valid,
    output lane_unshifter_port_out_ready
  );

  // Unshifter side.
  modport slave (
    input  lane_unshifter_port_input,
    input  lane_unshifter_port_sr,
    input  lane_unshifter_port_shift,
    input  lane_unshifter_port_direction,
    input  lane_unshifter_port_in_valid,
    output lane_unshifter_port_in_ready,
    output lane_unshifter_port_output,
    output lane_unshifter_port_lost,
    output lane_unshifter_port_out_valid,
    input  lane_unshifter_port_out_ready
  );

endinterface

// File: rtl/lane_unshifter_lane_step.sv
// rtl/lane_unshifter_lane_step.sv - one-bit rotate/shift of a single lane with carry-out
module lane_step import shift_pkg::*; #(
  parameter int LANE_W = shift_pkg::LANE_W
) (
  input  logic [LANE_W-1:0] i_lane,
  input  logic              i_rotate,
  input  logic              i_move_right,
  output logic [LANE_W-1:0] o_lane,
  output logic              o_carry
);

  // The exiting bit wraps to the far end when rotating, otherwise zero fills.
  always_comb begin
    o_lane  = i_lane;
    o_carry = 1'b0;
    if (i_move_right) begin
      o_carry = i_lane[0];
      o_lane  = {i_rotate & i_lane[0], i_lane[LANE_W-1:1]};
    end else begin
      o_carry = i_lane[LANE_W-1];
      o_lane  = {i_lane[LANE_W-2:0], i_rotate & i_lane[LANE_W-1]};
    end
  end

endmodule

// File: rtl/lane_unshifter.sv
// rtl/lane_unshifter.sv - iterative per-lane inverse of the lane barrel shifter
module lane_unshifter import shift_pkg::*; #(
  parameter int LANES   = shift_pkg::LANES,
  parameter int LANE_W  = shift_pkg::LANE_W,
  parameter int SHIFT_W = shift_pkg::SHIFT_W
) (
  input  logic              lane_unshifter_port_clk,
  input  logic              lane_unshifter_port_reset,
  lane_unshifter_if.slave   bus
);

  localparam int DATA_W = LANES * LANE_W;

  state_t              r_state;
  state_t              w_next_state;
  logic [DATA_W-1:0]   r_work;
  logic [DATA_W-1:0]   w_stepped;
  logic [LANES-1:0]    w_carry;
  logic                r_sr;
  logic                r_dir;
  logic                r_lost;
  logic [SHIFT_W-1:0]  r_count;
  logic [SHIFT_W-1:0]  w_amount;
  logic                w_accept;
  logic                w_step;
  logic                w_rotate;
  logic                w_move_right;

  assign w_amount     = SHIFT_W'(wrap_amount(32'(bus.lane_unshifter_port_shift), LANE_W));
  assign w_accept     = (r_state == IDLE) && bus.lane_unshifter_port_in_valid;
  assign w_step       = (r_state == SHIFT) && (r_count != '0);
  assign w_rotate     = (r_sr == SR_ROTATE);
  // Undo a forward left shift by moving right, and vice versa.
  assign w_move_right = (r_dir == DIR_LEFT);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_step #(
      .LANE_W (LANE_W)
    ) u_lane_step (
      .i_lane       (r_work[g*LANE_W +: LANE_W]),
      .i_rotate     (w_rotate),
      .i_move_right (w_move_right),
      .o_lane       (w_stepped[g*LANE_W +: LANE_W]),
      .o_carry      (w_carry[g])
    );
  end

  // State register; reset drops any in-flight word.
  always_ff @(posedge lane_unshifter_port_clk) begin
    if (lane_unshifter_port_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: one idle cycle between result handshake and the next accept.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.lane_unshifter_port_in_valid) begin
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (r_count == '0) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (bus.lane_unshifter_port_out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Work register, latched fields and step counter; fields sampled only on accept.
  always_ff @(posedge lane_unshifter_port_clk) begin
    if (lane_unshifter_port_reset) begin
      r_work  <= '0;
      r_sr    <= 1'b0;
      r_dir   <= 1'b0;
      r_count <= '0;
      r_lost  <= 1'b0;
    end else if (w_accept) begin
      r_work  <= bus.lane_unshifter_port_input;
      r_sr    <= bus.lane_unshifter_port_sr;
      r_dir   <= bus.lane_unshifter_port_direction;
      r_count <= w_amount;
      r_lost  <= 1'b0;
    end else if (w_step) begin
      r_work  <= w_stepped;
      r_count <= r_count - SHIFT_W'(1);
      if (r_sr == SR_SHIFT) begin
        r_lost <= r_lost | (|w_carry);
      end
    end
  end

  assign bus.lane_unshifter_port_in_ready  = (r_state == IDLE);
  assign bus.lane_unshifter_port_out_valid = (r_state == DONE);
  assign bus.lane_unshifter_port_output    = (r_state == DONE) ? r_work : '0;
  assign bus.lane_unshifter_port_lost      = (r_state == DONE) & r_lost;

endmodule

// File: doc/lane_unshifter.md
Name: lane_unshifter

Overview:
- Sequential inverse of the 32-bit lane-wise barrel shifter. It takes a word that was shifted or rotated per 4-bit lane, plus the same command fields (sr, shift amount, direction), and restores the pre-shift word.
- Works iteratively, one bit position per cycle, opposite to the commanded direction.
- Sits on the receive side of the shift path, with valid/ready handshakes on both ends.

Parameters:
- LANES, 8, number of independent lanes.
- LANE_W, 4, bits per lane; data width is LANES*LANE_W.
- SHIFT_W, 2, width of the shift amount, equal to clog2(LANE_W).

Ports:
- lane_unshifter_port_clk  input  1  clock; all state updates on the rising edge.
- lane_unshifter_port_reset  input  1  synchronous, active-high reset.
- lane_unshifter_port_input  input  LANES*LANE_W  shifted word to restore.
- lane_unshifter_port_sr  input  1  1 = rotate, 0 = logical shift (zero fill).
- lane_unshifter_port_shift  input  SHIFT_W  forward shift amount, 0..LANE_W-1.
- lane_unshifter_port_direction  input  1  forward direction: 1 = left, 0 = right. The block moves data the opposite way.
- lane_unshifter_port_in_valid  input  1  command/data valid.
- lane_unshifter_port_in_ready  output  1  block can accept a command.
- lane_unshifter_port_output  output  LANES*LANE_W  restored word.
- lane_unshifter_port_lost  output  1  a nonzero bit was discarded during a logical unshift.
- lane_unshifter_port_out_valid  output  1  output word valid.
- lane_unshifter_port_out_ready  input  1  consumer accepts the output.

Behaviour:
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, output = 0, lost = 0, count = 0.
  - Reset overrides everything, including mid-SHIFT or DONE; any in-flight word is dropped with no output.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready:
    - latch data into the work register and latch sr and direction;
    - count <= shift; lost <= 0;
    - go to SHIFT.
  - SHIFT: in_ready = 0.
    - If count != 0, each lane moves 1 bit in the inverse direction (direction=1 moves right, direction=0 moves left), then count <= count-1.
    - Rotate (sr=1): the bit leaving a lane re-enters at the opposite end of the same lane.
    - Logical (sr=0): zero fill. The exiting bit of each lane is ORed into lost.
    - If count == 0: go to DONE.
  - DONE: out_valid = 1 and output = work register. Output and lost stay stable while out_ready = 0. On out_ready, go to IDLE.
- Lane isolation: bits never cross lane boundaries.
- Latency: out_valid rises k+1 cycles after the accepting edge, where k = shift amount. Amount 0 gives 1 cycle; amount 3 gives 4 cycles.
- Throughput: no same-cycle accept in DONE. A new command is accepted at earliest the cycle after the output handshake.
- Handshake hygiene:
  - Input fields are sampled only on the accepting edge; later changes are ignored.
  - in_valid in non-IDLE states is ignored, with no queuing.
  - in_valid and out_ready may be high in the same cycle; each is evaluated against the current state only.
- Width rules:
  - count is SHIFT_W bits and never underflows.
  - A shift amount >= LANE_W cannot occur with default parameters. If parameters allow it, the amount is taken modulo LANE_W.

Decomposition:
- Shared package (shift_pkg) holds:
  - state enum IDLE/SHIFT/DONE;
  - constants LANE_W, LANES, SHIFT_W;
  - direction encodings DIR_LEFT = 1, DIR_RIGHT = 0;
  - sr encodings SR_ROTATE = 1, SR_SHIFT = 0.
- One natural sub-module, lane_step, is a combinational 1-bit rotate/shift of one lane with carry-out. It is generated LANES times; the FSM and counter live in the top.

Test Plan:
- Rotate inverse: input 0x12345678, sr=1, direction=1, shift=1 -> output 0x8192A3B4, lost=0, out_valid 2 cycles after accept.
- Logical inverse: input 0xF0F0F0F0, sr=0, direction=0, shift=2 -> output 0xC0C0C0C0, lost=1, out_valid 3 cycles after accept.
- Zero amount: input 0xDEADBEEF, shift=0, sr=0 -> output 0xDEADBEEF, lost=0, out_valid 1 cycle after accept.
- Backpressure: complete a command, then hold out_ready=0 for 5 cycles with in_valid=1 -> output/lost stable, in_ready=0, no second accept. Release out_ready -> IDLE the next cycle, then accept.
- Reset mid-operation: accept shift=3, assert reset in the 2nd SHIFT cycle -> next cycle IDLE, in_ready=1, out_valid=0, output=0, and no later out_valid.
- Round trip: random 32-bit X through the forward lane shifter (sr=1, any direction/amount), then through this block with identical fields -> output == X over 1000 vectors.
